// File: rtl/tlb_op_sequencer_pkg.sv
// Shared types for the TLB op sequencer: sizes, op encodings and FSM states.
// Pure declarations, no latency or flow-control behaviour of its own.
package tlb_op_sequencer_pkg;

  localparam int TLBNUM = 8;
  localparam int IDX_W  = $clog2(TLBNUM);
  localparam int TLB_WD = 32;

  localparam logic [IDX_W-1:0] RANDOM_TOP = IDX_W'(TLBNUM - 1);

  typedef enum logic [1:0] {
    TLBOP_P  = 2'b00,
    TLBOP_R  = 2'b01,
    TLBOP_WI = 2'b10,
    TLBOP_WR = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PROBE    = 3'd1,
    ST_PROBE_WB = 3'd2,
    ST_READ     = 3'd3,
    ST_READ_WB  = 3'd4,
    ST_WRITE    = 3'd5,
    ST_REFETCH  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/tlb_op_sequencer_if.sv
// Bundle between MEM stage / CP0 / bridge (master) and the TLB op sequencer (slave).
// Op request uses a valid/ready handshake; all other signals are per-cycle strobes.
interface tlb_op_sequencer_if;
  import tlb_op_sequencer_pkg::*;

  logic              op_valid;
  logic [1:0]        op_type;
  logic              op_ready;
  logic              flush;
  logic              dmem_req;
  logic              dmem_grant;
  logic [IDX_W-1:0]  cp0_wired;
  logic              cp0_wired_we;
  logic [IDX_W-1:0]  cp0_index;
  logic              is_tlbp;
  logic              is_tlbr;
  logic              is_tlbwi;
  logic              is_tlbwr;
  logic [IDX_W-1:0]  w_random;
  logic [IDX_W-1:0]  tlbr_index;
  logic [TLB_WD-1:0] tlbp_result;
  logic              index_we;
  logic [TLB_WD-1:0] index_wdata;
  logic              entry_we;
  logic [IDX_W-1:0]  cp0_random;
  logic              refetch_req;
  logic              busy;

  modport master (
    output op_valid, op_type, flush, dmem_req, cp0_wired, cp0_wired_we, cp0_index, tlbp_result,
    input  op_ready, dmem_grant, is_tlbp, is_tlbr, is_tlbwi, is_tlbwr, w_random, tlbr_index,
           index_we, index_wdata, entry_we, cp0_random, refetch_req, busy
  );

  modport slave (
    input  op_valid, op_type, flush, dmem_req, cp0_wired, cp0_wired_we, cp0_index, tlbp_result,
    output op_ready, dmem_grant, is_tlbp, is_tlbr, is_tlbwi, is_tlbwr, w_random, tlbr_index,
           index_we, index_wdata, entry_we, cp0_random, refetch_req, busy
  );

endinterface

// File: rtl/tlb_op_sequencer_random_cnt.sv
// CP0 Random counter: free-running down-count from TLBNUM-1 that wraps at Wired.
// Updates every cycle; a Wired write restarts it at the top on the next cycle.
module tlb_op_sequencer_random_cnt
  import tlb_op_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  logic [IDX_W-1:0] random_d;
  logic [IDX_W-1:0] random_q;

  // Wired at or above the top leaves no random slots, so pin to the top entry.
  always_comb begin
    random_d = random_q - IDX_W'(1);
    if (wired_we || (random_q == wired) || (wired >= RANDOM_TOP)) begin
      random_d = RANDOM_TOP;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_q <= RANDOM_TOP;
    end else begin
      random_q <= random_d;
    end
  end

  assign random = random_q;

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences one TLBP/TLBR/TLBWI/TLBWR at a time: 2 cycles from accept to CP0 writeback or refetch.
// op_ready drops while busy, while flushing, or while the data side holds search port 1.
module tlb_op_sequencer
  import tlb_op_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  tlb_op_sequencer_if.slave tif
);

  seq_state_e        state_d, state_q;
  logic              is_tlbp_d, is_tlbp_q;
  logic              is_tlbr_d, is_tlbr_q;
  logic              is_tlbwi_d, is_tlbwi_q;
  logic              is_tlbwr_d, is_tlbwr_q;
  logic              index_we_d, index_we_q;
  logic              entry_we_d, entry_we_q;
  logic              refetch_req_d, refetch_req_q;
  logic              busy_d, busy_q;
  logic [IDX_W-1:0]  w_random_d, w_random_q;
  logic [IDX_W-1:0]  tlbr_index_d, tlbr_index_q;
  logic [TLB_WD-1:0] index_wdata_d, index_wdata_q;
  logic [IDX_W-1:0]  random;
  logic              accept;
  tlb_op_e           op;

  tlb_op_sequencer_random_cnt u_random (
    .clk      (clk),
    .resetn   (resetn),
    .wired    (tif.cp0_wired),
    .wired_we (tif.cp0_wired_we),
    .random   (random)
  );

  // resetn gate keeps the MEM stage from seeing a handshake the flops cannot take.
  assign accept = (state_q == ST_IDLE) && tif.op_valid && !tif.dmem_req && !tif.flush && resetn;
  assign op     = tlb_op_e'(tif.op_type);

  always_comb begin
    state_d       = state_q;
    w_random_d    = w_random_q;
    tlbr_index_d  = tlbr_index_q;
    index_wdata_d = index_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            TLBOP_P: state_d = ST_PROBE;
            TLBOP_R: begin
              state_d      = ST_READ;
              tlbr_index_d = tif.cp0_index;
            end
            TLBOP_WI: state_d = ST_WRITE;
            TLBOP_WR: begin
              state_d    = ST_WRITE;
              w_random_d = random;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_PROBE: begin
        if (tif.flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d       = ST_PROBE_WB;
          index_wdata_d = tif.tlbp_result;
        end
      end
      ST_READ:     state_d = tif.flush ? ST_IDLE : ST_READ_WB;
      ST_WRITE:    state_d = ST_REFETCH;
      ST_PROBE_WB,
      ST_READ_WB,
      ST_REFETCH:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // WRITE is only ever entered straight from an accept, so its strobe comes from the op.
    is_tlbp_d     = (state_d == ST_PROBE);
    is_tlbr_d     = (state_d == ST_READ);
    is_tlbwi_d    = accept && (op == TLBOP_WI);
    is_tlbwr_d    = accept && (op == TLBOP_WR);
    index_we_d    = (state_d == ST_PROBE_WB);
    entry_we_d    = (state_d == ST_READ_WB);
    refetch_req_d = (state_d == ST_REFETCH);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      is_tlbp_q     <= 1'b0;
      is_tlbr_q     <= 1'b0;
      is_tlbwi_q    <= 1'b0;
      is_tlbwr_q    <= 1'b0;
      index_we_q    <= 1'b0;
      entry_we_q    <= 1'b0;
      refetch_req_q <= 1'b0;
      busy_q        <= 1'b0;
      w_random_q    <= '0;
      tlbr_index_q  <= '0;
      index_wdata_q <= '0;
    end else begin
      state_q       <= state_d;
      is_tlbp_q     <= is_tlbp_d;
      is_tlbr_q     <= is_tlbr_d;
      is_tlbwi_q    <= is_tlbwi_d;
      is_tlbwr_q    <= is_tlbwr_d;
      index_we_q    <= index_we_d;
      entry_we_q    <= entry_we_d;
      refetch_req_q <= refetch_req_d;
      busy_q        <= busy_d;
      w_random_q    <= w_random_d;
      tlbr_index_q  <= tlbr_index_d;
      index_wdata_q <= index_wdata_d;
    end
  end

  assign tif.op_ready    = accept;
  assign tif.dmem_grant  = tif.dmem_req && (state_q != ST_PROBE);
  assign tif.is_tlbp     = is_tlbp_q;
  assign tif.is_tlbr     = is_tlbr_q;
  assign tif.is_tlbwi    = is_tlbwi_q;
  assign tif.is_tlbwr    = is_tlbwr_q;
  assign tif.index_we    = index_we_q;
  assign tif.entry_we    = entry_we_q;
  assign tif.refetch_req = refetch_req_q;
  assign tif.busy        = busy_q;
  assign tif.w_random    = w_random_q;
  assign tif.tlbr_index  = tlbr_index_q;
  assign tif.index_wdata = index_wdata_q;
  assign tif.cp0_random  = random;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Bench for tlb_op_sequencer: directed scenarios then random traffic against a
// per-op event-schedule model of the sequencer and an arithmetic Random model.
module tb_tlb_op_sequencer;
  import tlb_op_sequencer_pkg::*;

  localparam int EV_P  = 1;
  localparam int EV_R  = 2;
  localparam int EV_WI = 4;
  localparam int EV_WR = 8;
  localparam int EV_IW = 16;
  localparam int EV_EW = 32;
  localparam int EV_RF = 64;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tlb_op_sequencer_if tif();

  tlb_op_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .tif    (tif)
  );

  int errors = 0;
  int checks = 0;

  // Model: queue of expected strobe sets for the coming cycles of the op in flight.
  int          m_q[$];
  int          m_rnd;
  int          m_wr;
  int          m_ridx;
  logic [31:0] m_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] obs_ev();
    return {tif.refetch_req, tif.entry_we, tif.index_we, tif.is_tlbwr,
            tif.is_tlbwi, tif.is_tlbr, tif.is_tlbp};
  endfunction

  // Compare the current cycle against the model at negedge, then advance the model.
  task automatic tick();
    int   ev;
    logic rdy;
    @(negedge clk);
    ev  = (m_q.size() != 0) ? m_q[0] : 0;
    rdy = (m_q.size() == 0) && tif.op_valid && !tif.dmem_req && !tif.flush;
    check("events", 32'(obs_ev()), 32'(ev));
    check("busy", 32'(tif.busy), 32'(m_q.size() != 0));
    check("op_ready", 32'(tif.op_ready), 32'(rdy));
    check("dmem_grant", 32'(tif.dmem_grant), 32'(tif.dmem_req && (ev != EV_P)));
    check("cp0_random", 32'(tif.cp0_random), 32'(m_rnd));
    check("w_random", 32'(tif.w_random), 32'(m_wr));
    if (ev == EV_IW) check("index_wdata", tif.index_wdata, m_idx);
    if (ev == EV_R || ev == EV_EW) check("tlbr_index", 32'(tif.tlbr_index), 32'(m_ridx));
    if (m_q.size() != 0) begin
      if (tif.flush && (ev == EV_P || ev == EV_R)) begin
        m_q.delete();
      end else begin
        if (ev == EV_P) m_idx = tif.tlbp_result;
        void'(m_q.pop_front());
      end
    end else if (rdy) begin
      case (tif.op_type)
        2'd0: m_q = {EV_P, EV_IW};
        2'd1: begin m_q = {EV_R, EV_EW}; m_ridx = int'(tif.cp0_index); end
        2'd2: m_q = {EV_WI, EV_RF};
        default: begin m_q = {EV_WR, EV_RF}; m_wr = m_rnd; end
      endcase
    end
    if (tif.cp0_wired_we || m_rnd == int'(tif.cp0_wired) || int'(tif.cp0_wired) >= TLBNUM - 1)
      m_rnd = TLBNUM - 1;
    else
      m_rnd = m_rnd - 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [2:0] idx;
    resetn = 1'b0;
    tif.op_valid = 1'b1; tif.op_type = TLBOP_P; tif.flush = 1'b0; tif.dmem_req = 1'b1;
    tif.cp0_wired = '0; tif.cp0_wired_we = 1'b0; tif.cp0_index = '0; tif.tlbp_result = '0;
    m_rnd = TLBNUM - 1; m_wr = 0; m_idx = '0; m_ridx = 0;

    // Reset state
    #12;
    check("rst_events", 32'(obs_ev()), 32'd0);
    check("rst_busy", 32'(tif.busy), 32'd0);
    check("rst_random", 32'(tif.cp0_random), 32'd7);
    check("rst_w_random", 32'(tif.w_random), 32'd0);
    check("rst_index_wdata", tif.index_wdata, 32'd0);
    check("rst_dmem_grant_on", 32'(tif.dmem_grant), 32'd1);
    tif.dmem_req = 1'b0;
    #1;
    check("rst_dmem_grant_off", 32'(tif.dmem_grant), 32'd0);
    check("rst_op_ready", 32'(tif.op_ready), 32'd0);
    tif.op_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // 1: TLBP hit on entry 5
    tif.op_valid = 1'b1; tif.op_type = TLBOP_P; tif.tlbp_result = 32'h0000_0005;
    tick();
    tif.op_valid = 1'b0;
    #1 check("t1_is_tlbp", 32'(tif.is_tlbp), 32'd1);
    tick();
    #1 check("t1_index_we", 32'(tif.index_we), 32'd1);
    check("t1_index_wdata", tif.index_wdata, 32'h0000_0005);
    tick();

    // 2: TLBP miss, data side stalled during PROBE
    tif.op_valid = 1'b1; tif.tlbp_result = 32'h8000_0000;
    tick();
    tif.op_valid = 1'b0; tif.dmem_req = 1'b1;
    #1 check("t2_grant_probe", 32'(tif.dmem_grant), 32'd0);
    tick();
    #1 check("t2_grant_after", 32'(tif.dmem_grant), 32'd1);
    check("t2_index_wdata", tif.index_wdata, 32'h8000_0000);
    tick();
    tif.dmem_req = 1'b0;

    // 3: TLBWR with Wired=2 and Random=2 at accept
    tif.cp0_wired = 3'd2; tif.cp0_wired_we = 1'b1;
    tick();
    tif.cp0_wired_we = 1'b0;
    for (int i = 0; i < 20 && m_rnd != 2; i++) tick();
    check("t3_random_pre", 32'(tif.cp0_random), 32'd2);
    tif.op_valid = 1'b1; tif.op_type = TLBOP_WR;
    tick();
    tif.op_valid = 1'b0;
    #1 check("t3_w_random", 32'(tif.w_random), 32'd2);
    check("t3_is_tlbwr", 32'(tif.is_tlbwr), 32'd1);
    check("t3_random_wrap", 32'(tif.cp0_random), 32'd7);
    tick();
    #1 check("t3_refetch", 32'(tif.refetch_req), 32'd1);
    tick();
    tick();
    tif.cp0_wired_we = 1'b1;
    tick();
    tif.cp0_wired_we = 1'b0;
    #1 check("t3_wired_we_restart", 32'(tif.cp0_random), 32'd7);

    // 4: TLBR index 3, held off by data-side request
    tif.op_valid = 1'b1; tif.op_type = TLBOP_R; tif.cp0_index = 3'd3; tif.dmem_req = 1'b1;
    #1 check("t4_ready_blocked", 32'(tif.op_ready), 32'd0);
    tick();
    tick();
    tif.dmem_req = 1'b0;
    tick();
    tif.op_valid = 1'b0; tif.cp0_index = 3'd6;
    #1 check("t4_is_tlbr", 32'(tif.is_tlbr), 32'd1);
    check("t4_tlbr_index", 32'(tif.tlbr_index), 32'd3);
    tick();
    #1 check("t4_entry_we", 32'(tif.entry_we), 32'd1);
    check("t4_tlbr_index_held", 32'(tif.tlbr_index), 32'd3);
    tick();

    // 5: flush aborts PROBE but not WRITE
    tif.op_valid = 1'b1; tif.op_type = TLBOP_P;
    tick();
    tif.op_valid = 1'b0; tif.flush = 1'b1;
    tick();
    tif.flush = 1'b0;
    #1 check("t5_probe_abort_busy", 32'(tif.busy), 32'd0);
    check("t5_probe_abort_we", 32'(tif.index_we), 32'd0);
    tick();
    tif.op_valid = 1'b1; tif.op_type = TLBOP_WI;
    tick();
    tif.op_valid = 1'b0; tif.flush = 1'b1;
    #1 check("t5_is_tlbwi", 32'(tif.is_tlbwi), 32'd1);
    tick();
    tif.flush = 1'b0;
    #1 check("t5_refetch_after_flush", 32'(tif.refetch_req), 32'd1);
    tick();

    // 6: reset asserted during READ_WB
    tif.op_valid = 1'b1; tif.op_type = TLBOP_R; tif.cp0_index = 3'd4;
    tick();
    tif.op_valid = 1'b0;
    tick();
    #1 check("t6_entry_we_pre", 32'(tif.entry_we), 32'd1);
    resetn = 1'b0;
    #1 check("t6_entry_we_rst", 32'(tif.entry_we), 32'd0);
    check("t6_random_rst", 32'(tif.cp0_random), 32'd7);
    check("t6_busy_rst", 32'(tif.busy), 32'd0);
    m_q.delete(); m_rnd = TLBNUM - 1; m_wr = 0; m_idx = '0; m_ridx = 0;
    resetn = 1'b1;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      idx = 3'($urandom_range(0, 7));
      tif.op_valid     = 1'($urandom_range(0, 1));
      tif.op_type      = 2'($urandom_range(0, 3));
      tif.dmem_req     = ($urandom_range(0, 3) == 0);
      tif.flush        = ($urandom_range(0, 7) == 0);
      tif.cp0_index    = 3'($urandom_range(0, 7));
      tif.tlbp_result  = {1'($urandom_range(0, 1)), 28'b0, idx};
      tif.cp0_wired_we = ($urandom_range(0, 15) == 0);
      if (tif.cp0_wired_we) tif.cp0_wired = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
